// File: rtl/snowbro2_gfx_arbiter.sv
// Round-robin arbiter sharing one SDRAM bank read port among the four graphics ROM
// slots (GFX, SCR0..2). It keeps a one-entry tag/data cache per slot.
module snowbro2_gfx_arbiter #(
    parameter logic [21:0] SCR0_OFFSET = 22'h000000,
    parameter logic [21:0] SCR1_OFFSET = 22'h000000,
    parameter logic [21:0] SCR2_OFFSET = 22'h000000,
    parameter logic [21:0] OBJ_OFFSET  = 22'h000000
) (
    input  logic         CLK,
    input  logic         RESET_N,
    input  logic [3:0]   REQ_CS,
    input  logic [87:0]  REQ_ADDR,
    output logic [3:0]   REQ_OK,
    output logic [127:0] REQ_DOUT,
    output logic [21:0]  BA_ADDR,
    output logic         BA_RD,
    input  logic         BA_ACK,
    input  logic         BA_DOK,
    input  logic         BA_RDY,
    input  logic [15:0]  DATA_READ
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    function automatic logic [21:0] slot_offset(input logic [1:0] slot);
        logic [21:0] off;
        case (slot)
            2'd0:    off = OBJ_OFFSET;
            2'd1:    off = SCR0_OFFSET;
            2'd2:    off = SCR1_OFFSET;
            2'd3:    off = SCR2_OFFSET;
            default: off = 22'h000000;
        endcase
        return off;
    endfunction

    state_e            state_q, state_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [21:0]       gaddr_q, gaddr_d;
    logic              wcnt_q, wcnt_d;
    logic [15:0]       lo_q, lo_d;
    logic [21:0]       ba_addr_q, ba_addr_d;
    logic              ba_rd_q, ba_rd_d;
    logic [3:0]        valid_q, valid_d;
    logic [3:0][21:0]  tag_q, tag_d;
    logic [3:0][31:0]  data_q, data_d;
    logic [3:0]        ok_q, ok_d;

    logic [3:0][21:0]  addr_s;
    logic [3:0]        hit_s;
    logic [3:0]        pending_s;
    logic              found_s;
    logic [1:0]        pick_s;
    logic              fill_s;
    logic [31:0]       fill_data_s;

    // Cache lookup and pending detection; the in-flight slot is not pending for its own address
    always_comb begin
        addr_s    = '0;
        hit_s     = 4'b0000;
        pending_s = 4'b0000;
        for (int n = 0; n < 4; n++) begin
            addr_s[n]    = REQ_ADDR[22*n +: 22];
            hit_s[n]     = valid_q[n] && (tag_q[n] == addr_s[n]);
            pending_s[n] = REQ_CS[n] && !hit_s[n] &&
                           !((state_q != ST_IDLE) && (gnt_q == 2'(n)) && (gaddr_q == addr_s[n]));
        end
    end

    // First pending slot at or after the round-robin pointer
    always_comb begin
        found_s = 1'b0;
        pick_s  = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!found_s && pending_s[ptr_q + 2'(i)]) begin
                found_s = 1'b1;
                pick_s  = ptr_q + 2'(i);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Fetch FSM next-state and bank-side outputs
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        gaddr_d     = gaddr_q;
        wcnt_d      = wcnt_q;
        lo_d        = lo_q;
        ba_addr_d   = ba_addr_q;
        ba_rd_d     = ba_rd_q;
        fill_s      = 1'b0;
        fill_data_s = 32'h0000_0000;
        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    gnt_d     = pick_s;
                    gaddr_d   = addr_s[pick_s];
                    ba_addr_d = addr_s[pick_s] + slot_offset(pick_s);
                    ba_rd_d   = 1'b1;
                    state_d   = ST_REQ;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (BA_ACK) begin
                    ba_rd_d = 1'b0;
                    wcnt_d  = 1'b0;
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_DATA: begin
                if (BA_DOK) begin
                    if (wcnt_q) begin
                        fill_s      = 1'b1;
                        fill_data_s = {DATA_READ, lo_q};
                    end else if (BA_RDY) begin
                        // Early end of burst: keep the lower half, zero the upper half
                        fill_s      = 1'b1;
                        fill_data_s = {16'h0000, DATA_READ};
                    end else begin
                        lo_d   = DATA_READ;
                        wcnt_d = 1'b1;
                    end
                end else begin
                    fill_s = 1'b0;
                end
                if (fill_s) begin
                    ptr_d   = gnt_q + 2'd1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DATA;
                end
            end
            default: begin
                ba_rd_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Cache fill and registered per-slot data-valid, with bypass on the fill cycle
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        ok_d    = 4'b0000;
        if (fill_s) begin
            valid_d[gnt_q] = 1'b1;
            tag_d[gnt_q]   = gaddr_q;
            data_d[gnt_q]  = fill_data_s;
        end else begin
            valid_d = valid_q;
        end
        for (int n = 0; n < 4; n++) begin
            ok_d[n] = REQ_CS[n] &&
                      (hit_s[n] || (fill_s && (gnt_q == 2'(n)) && (gaddr_q == addr_s[n])));
        end
    end

    // State and cache registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= ST_IDLE;
            ptr_q     <= 2'd0;
            gnt_q     <= 2'd0;
            gaddr_q   <= 22'h000000;
            wcnt_q    <= 1'b0;
            lo_q      <= 16'h0000;
            ba_addr_q <= 22'h000000;
            ba_rd_q   <= 1'b0;
            valid_q   <= 4'b0000;
            tag_q     <= '0;
            data_q    <= '0;
            ok_q      <= 4'b0000;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            gaddr_q   <= gaddr_d;
            wcnt_q    <= wcnt_d;
            lo_q      <= lo_d;
            ba_addr_q <= ba_addr_d;
            ba_rd_q   <= ba_rd_d;
            valid_q   <= valid_d;
            tag_q     <= tag_d;
            data_q    <= data_d;
            ok_q      <= ok_d;
        end
    end

    assign REQ_OK   = ok_q;
    assign REQ_DOUT = data_q;
    assign BA_ADDR  = ba_addr_q;
    assign BA_RD    = ba_rd_q;

endmodule
